set_job_arbiter: RTL and testbench
==================================

// Module: set_job_arbiter
// PURPOSE
//  Shares one SET circle-candidate counting engine between N_REQ requesters.
//  Each requester submits a job: centres, radii and mode.
//  The block accepts one job at a time by round-robin, fires the engine, waits for its result and returns the
//  candidate count tagged with the requester id. It sits between the host-side job sources and the SET instance.
// PARAMETERS
//  N_REQ    4    number of requesters (2..8)
//  TIMEOUT  80   max cycles in WAIT before the job is aborted (engine nominal: 66)
// PORTS
//  clk            in   1          clock
//  rst            in   1          reset, asynchronous, active-high
//  req_valid      in   N_REQ      per-requester job pending
//  req_ready      out  N_REQ      one-hot accept strobe; a job transfers when valid&ready
//  req_central    in   24*N_REQ   packed centres, slice i = [24*i +: 24]
//  req_radius     in   12*N_REQ   packed radii, slice i = [12*i +: 12]
//  req_mode       in   2*N_REQ    packed modes, slice i = [2*i +: 2]
//  eng_en         out  1          one-cycle start pulse to engine
//  eng_central    out  24         job centres, held from ISSUE until job end
//  eng_radius     out  12         job radii, held likewise
//  eng_mode       out  2          job mode, held likewise (engine samples mode every busy cycle)
//  eng_busy       in   1          engine busy
//  eng_valid      in   1          engine result strobe
//  eng_candidate  in   8          engine result
//  rsp_valid      out  1          response available
//  rsp_ready      in   1          consumer accepts response
//  rsp_id         out  3          index of the requester that owns the response
//  rsp_candidate  out  8          candidate count; 0 on timeout
//  rsp_err        out  1          1 = job aborted by timeout
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, timeout counter 0, held job regs 0.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, grant the first set bit at or after the rr pointer (wrapping modulo N_REQ).
//         In the same cycle: req_ready[g]=1 (combinational, one-hot, only in IDLE), latch that job and g.
//         Then rr <= (g+1)%N_REQ and go to ISSUE. If there is no request, stay.
//   ISSUE: eng_en=1 for exactly this cycle; clear the timeout counter; go to WAIT.
//   WAIT: count cycles. On eng_valid, capture eng_candidate, rsp_err=0, and go to RESP.
//         If the counter reaches TIMEOUT-1 without eng_valid: rsp_candidate=0, rsp_err=1, go to RESP.
//         eng_busy is not used for completion; it is ignored.
//   RESP: rsp_valid=1 with rsp_id, rsp_candidate and rsp_err stable until rsp_ready. On the handshake cycle go to IDLE.
//         The earliest next grant is the cycle after the return to IDLE.
//  Throughput: one job per (engine latency + 3 + response stall) cycles. There is no job queue; requesters hold req_valid.
//  Boundaries:
//   - eng_valid in the same cycle as timeout expiry: the valid result wins and rsp_err=0.
//   - eng_valid outside WAIT is ignored.
//   - req_valid dropping before grant is allowed. No grant is given to a requester whose valid is low.
//   - rsp_id is 3 bits; the upper bits are 0 when N_REQ<8.
//   - rst asserted mid-job returns immediately to the reset state. Any pending response is lost and eng_* are cleared.
//  Fairness: with all requesters valid, grants are 0,1,2,3,0,... and no requester waits more than N_REQ-1 jobs.
// TESTING
//  1. Single req: req_valid=0001, central=24'h444_000, radius=12'h300, mode=0 -> one eng_en pulse; with a SET model,
//     rsp_valid, rsp_id=0, rsp_candidate=29, rsp_err=0.
//  2. All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0. req_ready is one-hot and appears only in IDLE.
//  3. Engine stub never raises eng_valid -> rsp_valid exactly TIMEOUT cycles after the WAIT entry,
//     with rsp_err=1, rsp_candidate=0. Then IDLE.
//  4. Hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable. No new req_ready or eng_en until the handshake.
//  5. Stub raises eng_valid on the timeout-expiry cycle with eng_candidate=8'd7 -> rsp_candidate=7, rsp_err=0.
//  6. Assert rst during WAIT -> all outputs 0 at once. The next job after release gets a normal response.

Source files
------------

// File: rtl/set_job_arbiter.sv
// rtl/set_job_arbiter.sv - round-robin job arbiter sharing one SET candidate-counting engine
module set_job_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [24*N_REQ-1:0]  req_central,
    input  logic [12*N_REQ-1:0]  req_radius,
    input  logic [2*N_REQ-1:0]   req_mode,
    output logic                 eng_en,
    output logic [23:0]          eng_central,
    output logic [11:0]          eng_radius,
    output logic [1:0]           eng_mode,
    input  logic                 eng_busy,
    input  logic                 eng_valid,
    input  logic [7:0]           eng_candidate,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2:0]           rsp_id,
    output logic [7:0]           rsp_candidate,
    output logic                 rsp_err
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_rr;
    logic [CW-1:0]   r_tcnt;
    logic [23:0]     r_central;
    logic [11:0]     r_radius;
    logic [1:0]      r_mode;
    logic [2:0]      r_id;
    logic [7:0]      r_cand;
    logic            r_err;

    logic            w_gnt_any;
    logic [2:0]      w_gnt_idx;
    logic            w_hi_found;
    logic [2:0]      w_hi_idx;
    logic [2:0]      w_lo_idx;
    logic [23:0]     w_sel_central;
    logic [11:0]     w_sel_radius;
    logic [1:0]      w_sel_mode;
    logic            w_tmo;
    logic            w_unused;

    // Completion is signalled by eng_valid alone; busy is deliberately not consulted.
    assign w_unused = eng_busy;

    assign w_tmo = (r_tcnt == CW'(TIMEOUT - 1));

    // Round-robin search: lowest valid index at or above the pointer, else lowest valid overall.
    always_comb begin
        w_gnt_any  = 1'b0;
        w_hi_found = 1'b0;
        w_hi_idx   = 3'd0;
        w_lo_idx   = 3'd0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                w_gnt_any = 1'b1;
                w_lo_idx  = 3'(k);
                if (3'(k) >= r_rr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = 3'(k);
                end
            end
        end
        w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    // Mux out the granted requester's job fields.
    always_comb begin
        w_sel_central = 24'd0;
        w_sel_radius  = 12'd0;
        w_sel_mode    = 2'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt_idx == 3'(k)) begin
                w_sel_central = req_central[24*k +: 24];
                w_sel_radius  = req_radius[12*k +: 12];
                w_sel_mode    = req_mode[2*k +: 2];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        eng_en    = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_any) begin
                    for (int k = 0; k < N_REQ; k++) begin
                        req_ready[k] = (w_gnt_idx == 3'(k));
                    end
                    w_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                eng_en = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (eng_valid || w_tmo) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Job latch, rr pointer, timeout counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr      <= 3'd0;
            r_tcnt    <= '0;
            r_central <= 24'd0;
            r_radius  <= 12'd0;
            r_mode    <= 2'd0;
            r_id      <= 3'd0;
            r_cand    <= 8'd0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_any) begin
                        r_central <= w_sel_central;
                        r_radius  <= w_sel_radius;
                        r_mode    <= w_sel_mode;
                        r_id      <= w_gnt_idx;
                        r_rr      <= (w_gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : w_gnt_idx + 3'd1;
                    end
                end
                S_ISSUE: begin
                    r_tcnt <= '0;
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // A result arriving on the expiry cycle still counts as success.
                    if (eng_valid) begin
                        r_cand <= eng_candidate;
                        r_err  <= 1'b0;
                    end else if (w_tmo) begin
                        r_cand <= 8'd0;
                        r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_central   = r_central;
    assign eng_radius    = r_radius;
    assign eng_mode      = r_mode;
    assign rsp_id        = r_id;
    assign rsp_candidate = r_cand;
    assign rsp_err       = r_err;

endmodule

// File: tb/tb_set_job_arbiter.sv
// tb/tb_set_job_arbiter.sv - scoreboard bench for set_job_arbiter with a latency-programmable engine stub
module tb_set_job_arbiter;

    localparam int N   = 4;
    localparam int TMO = 80;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [24*N-1:0] req_central;
    logic [12*N-1:0] req_radius;
    logic [2*N-1:0]  req_mode;
    logic            eng_en;
    logic [23:0]     eng_central;
    logic [11:0]     eng_radius;
    logic [1:0]      eng_mode;
    logic            eng_busy;
    logic            eng_valid;
    logic [7:0]      eng_candidate;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [2:0]      rsp_id;
    logic [7:0]      rsp_candidate;
    logic            rsp_err;

    typedef struct {
        logic [2:0] id;
        logic [7:0] cand;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // engine stub controls
    int         stub_lat   = 66;
    bit         stub_never = 1'b0;
    bit         stub_force = 1'b0;
    logic [7:0] stub_fval  = 8'd0;
    logic       spur_valid = 1'b0;
    logic [7:0] spur_cand  = 8'd0;
    logic       stub_act;
    int         stub_n;
    logic       stub_valid;
    logic [7:0] stub_cand;

    always #5 clk = ~clk;

    set_job_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_central(req_central), .req_radius(req_radius), .req_mode(req_mode),
        .eng_en(eng_en), .eng_central(eng_central), .eng_radius(eng_radius), .eng_mode(eng_mode),
        .eng_busy(eng_busy), .eng_valid(eng_valid), .eng_candidate(eng_candidate),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_candidate(rsp_candidate), .rsp_err(rsp_err)
    );

    // Stand-in for the SET engine: the known reference job yields 29, others a fixed hash.
    function automatic logic [7:0] cand_model(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        if (c == 24'h444000 && r == 12'h300 && m == 2'd0) return 8'd29;
        return c[7:0] ^ r[7:0] ^ {6'd0, m} ^ 8'h5A;
    endfunction

    // eng_valid arrives stub_lat cycles after the eng_en cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_act   <= 1'b0;
            stub_n     <= 0;
            stub_valid <= 1'b0;
            stub_cand  <= 8'd0;
        end else begin
            stub_valid <= 1'b0;
            if (eng_en) begin
                stub_act <= 1'b1;
                stub_n   <= 1;
            end else if (stub_act) begin
                stub_n <= stub_n + 1;
                if (stub_n == stub_lat - 1 && !stub_never) begin
                    stub_valid <= 1'b1;
                    stub_cand  <= stub_force ? stub_fval : cand_model(eng_central, eng_radius, eng_mode);
                    stub_act   <= 1'b0;
                end
            end
        end
    end

    assign eng_busy      = stub_act;
    assign eng_valid     = stub_valid | spur_valid;
    assign eng_candidate = spur_valid ? spur_cand : (stub_valid ? stub_cand : 8'hEE);

    task automatic set_job(input int i, input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
        req_central[24*i +: 24] = c;
        req_radius[12*i +: 12]  = r;
        req_mode[2*i +: 2]      = m;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, eng_en, rsp_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got ready=%b en=%b rv=%b want 0", req_ready, eng_en, rsp_valid);
        end
        n_vec++;
        if ({eng_central, eng_radius, eng_mode} !== '0) begin
            n_err++;
            $display("FAIL reset_eng: got %h/%h/%h want 0", eng_central, eng_radius, eng_mode);
        end
        n_vec++;
        if ({rsp_id, rsp_candidate, rsp_err} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp: got id=%0d cand=%0d err=%b want 0", rsp_id, rsp_candidate, rsp_err);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if ({req_ready, eng_en, rsp_valid} !== '0) begin
            n_err++;
            $display("FAIL idle_quiet: got ready=%b en=%b rv=%b want 0", req_ready, eng_en, rsp_valid);
        end
    endtask

    task automatic test_round_robin;
        int   gexp[5] = '{0, 1, 2, 3, 0};
        int   gcount = 0;
        int   rcount = 0;
        bit   drop = 1'b0;
        logic [3:0] want;
        exp_t e;
        stub_lat = 20;
        for (int i = 0; i < N; i++) set_job(i, {8'(i + 1), 16'h1234}, 12'(12'h0A0 + i), 2'(i));
        for (int j = 0; j < 5; j++)
            exp_q.push_back('{3'(gexp[j]), cand_model({8'(gexp[j] + 1), 16'h1234}, 12'(12'h0A0 + gexp[j]), 2'(gexp[j])), 1'b0});
        req_valid = '1;
        #1;
        for (int cyc = 0; cyc < 2000 && rcount < 5; cyc++) begin
            if (drop) begin
                req_valid = '0;
                drop = 1'b0;
            end
            if (req_ready !== '0) begin
                n_vec++;
                want = (gcount < 5) ? (4'b0001 << gexp[gcount]) : 4'b0000;
                if (req_ready !== want || eng_en !== 1'b0 || rsp_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL rr_grant%0d: got ready=%b en=%b rv=%b want ready=%b outside ISSUE/RESP",
                             gcount, req_ready, eng_en, rsp_valid, want);
                end
                gcount++;
                if (gcount == 5) drop = 1'b1;
            end
            if (rsp_valid) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rr_rsp: got unexpected response id=%0d want none", rsp_id);
                end else begin
                    e = exp_q.pop_front();
                    if ({rsp_id, rsp_candidate, rsp_err} !== {e.id, e.cand, e.err}) begin
                        n_err++;
                        $display("FAIL rr_rsp%0d: got id=%0d cand=%0d err=%b want id=%0d cand=%0d err=%b",
                                 rcount, rsp_id, rsp_candidate, rsp_err, e.id, e.cand, e.err);
                    end
                end
                rcount++;
            end
            @(negedge clk);
            #1;
        end
        n_vec++;
        if (gcount != 5 || rcount != 5) begin
            n_err++;
            $display("FAIL rr_count: got grants=%0d rsps=%0d want 5/5", gcount, rcount);
        end
        req_valid = '0;
    endtask

    task automatic test_single;
        int   cyc = 0;
        int   en_cnt = 0;
        exp_t e;
        stub_lat = 66;
        set_job(0, 24'h444000, 12'h300, 2'd0);
        exp_q.push_back('{3'd0, 8'd29, 1'b0});
        req_valid = 4'b0001;
        #1;
        while (req_ready === '0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL single_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        #1;
        req_valid = '0;
        n_vec++;
        if ({eng_en, eng_central, eng_radius, eng_mode} !== {1'b1, 24'h444000, 12'h300, 2'd0}) begin
            n_err++;
            $display("FAIL single_issue: got en=%b %h/%h/%h want 1 444000/300/0", eng_en, eng_central, eng_radius, eng_mode);
        end
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
            if (eng_en) en_cnt++;
        end
        n_vec++;
        if (cyc != 67 || en_cnt != 0) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles, %0d extra eng_en want 67, 0", cyc, en_cnt);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_candidate, rsp_err} !== {1'b1, e.id, e.cand, e.err}) begin
            n_err++;
            $display("FAIL single_rsp: got v=%b id=%0d cand=%0d err=%b want 1 id=%0d cand=%0d err=%b",
                     rsp_valid, rsp_id, rsp_candidate, rsp_err, e.id, e.cand, e.err);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_done: got rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_timeout;
        int   cyc = 0;
        exp_t e;
        stub_never = 1'b1;
        set_job(2, 24'h0ABCDE, 12'h123, 2'd1);
        exp_q.push_back('{3'd2, 8'd0, 1'b1});
        req_valid = 4'b0100;
        #1;
        while (req_ready === '0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_vec++;
        if (req_ready !== 4'b0100) begin
            n_err++;
            $display("FAIL tmo_grant: got %b want 0100", req_ready);
        end
        @(negedge clk);
        #1;
        req_valid = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin @(negedge clk); #1; cyc++; end
        n_vec++;
        if (cyc != TMO + 1) begin
            n_err++;
            $display("FAIL tmo_latency: got %0d cycles after eng_en want %0d", cyc, TMO + 1);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_candidate, rsp_err} !== {1'b1, e.id, e.cand, e.err}) begin
            n_err++;
            $display("FAIL tmo_rsp: got v=%b id=%0d cand=%0d err=%b want 1 id=%0d cand=%0d err=%b",
                     rsp_valid, rsp_id, rsp_candidate, rsp_err, e.id, e.cand, e.err);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if ({rsp_valid, eng_en, req_ready} !== '0) begin
            n_err++;
            $display("FAIL tmo_idle: got rv=%b en=%b ready=%b want 0", rsp_valid, eng_en, req_ready);
        end
        stub_never = 1'b0;
    endtask

    task automatic test_resp_stall;
        int         cyc = 0;
        bit         bad = 1'b0;
        logic [2:0] cap_id;
        logic [7:0] cap_cand;
        logic       cap_err;
        exp_t       e;
        stub_lat = 10;
        rsp_ready = 1'b0;
        set_job(3, 24'h333333, 12'h033, 2'd3);
        set_job(1, 24'h111111, 12'h011, 2'd2);
        exp_q.push_back('{3'd3, cand_model(24'h333333, 12'h033, 2'd3), 1'b0});
        req_valid = 4'b1010;
        #1;
        while (req_ready === '0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_vec++;
        if (req_ready !== 4'b1000) begin
            n_err++;
            $display("FAIL stall_grant: got %b want 1000", req_ready);
        end
        @(negedge clk);
        #1;
        req_valid = 4'b0010;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(negedge clk); #1; cyc++; end
        e = exp_q.pop_front();
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_candidate, rsp_err} !== {1'b1, e.id, e.cand, e.err}) begin
            n_err++;
            $display("FAIL stall_rsp: got v=%b id=%0d cand=%0d err=%b want 1 id=%0d cand=%0d err=%b",
                     rsp_valid, rsp_id, rsp_candidate, rsp_err, e.id, e.cand, e.err);
        end
        cap_id = rsp_id;
        cap_cand = rsp_candidate;
        cap_err = rsp_err;
        for (int k = 0; k < 10; k++) begin
            if (rsp_valid !== 1'b1 || rsp_id !== cap_id || rsp_candidate !== cap_cand || rsp_err !== cap_err ||
                req_ready !== '0 || eng_en !== 1'b0) bad = 1'b1;
            spur_valid = (k == 3);
            spur_cand = 8'hA5;
            @(negedge clk);
            #1;
        end
        spur_valid = 1'b0;
        n_vec++;
        if (bad || rsp_candidate !== cap_cand) begin
            n_err++;
            $display("FAIL stall_hold: got cand=%0d rv=%b ready=%b want stable cand=%0d, no grant/issue",
                     rsp_candidate, rsp_valid, req_ready, cap_cand);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if ({rsp_valid, req_ready} !== {1'b0, 4'b0010}) begin
            n_err++;
            $display("FAIL stall_next_grant: got rv=%b ready=%b want 0 0010", rsp_valid, req_ready);
        end
        exp_q.push_back('{3'd1, cand_model(24'h111111, 12'h011, 2'd2), 1'b0});
        @(negedge clk);
        #1;
        req_valid = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 100) begin @(negedge clk); #1; cyc++; end
        e = exp_q.pop_front();
        n_vec++;
        if ({rsp_valid, rsp_id, rsp_candidate, rsp_err} !== {1'b1, e.id, e.cand, e.err}) begin
            n_err++;
            $display("FAIL stall_rsp2: got v=%b id=%0d cand=%0d err=%b want 1 id=%0d cand=%0d err=%b",
                     rsp_valid, rsp_id, rsp_candidate, rsp_err, e.id, e.cand, e.err);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_simul_timeout;
        int   cyc = 0;
        exp_t e;
        stub_lat = TMO;
        stub_force = 1'b1;
        stub_fval = 8'd7;
        set_job(0, 24'h0F0F0F, 12'h0F0, 2'd0);
        exp_q.push_back('{3'd0, 8'd7, 1'b0});
        req_valid = 4'b0001;
        #1;
        while (req_ready === '0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        n_vec++;
        if (req_ready !== 4'b0001) begin
            n_err++;
            $display("FAIL edge_grant: got %b want 0001", req_ready);
        end
        @(negedge clk);
        #1;
        req_valid = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin @(negedge clk); #1; cyc++; end
        e = exp_q.pop_front();
        n_vec++;
        if (cyc != TMO + 1 || {rsp_id, rsp_candidate, rsp_err} !== {e.id, e.cand, e.err}) begin
            n_err++;
            $display("FAIL edge_rsp: got %0d cycles id=%0d cand=%0d err=%b want %0d cycles id=%0d cand=%0d err=%b",
                     cyc, rsp_id, rsp_candidate, rsp_err, TMO + 1, e.id, e.cand, e.err);
        end
        stub_force = 1'b0;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset_mid_job;
        int   cyc = 0;
        exp_t e;
        stub_lat = 66;
        set_job(2, 24'h222222, 12'h222, 2'd2);
        req_valid = 4'b0100;
        #1;
        while (req_ready === '0 && cyc < 20) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        #1;
        req_valid = '0;
        repeat (5) @(negedge clk);
        #1;
        n_vec++;
        if (eng_central !== 24'h222222) begin
            n_err++;
            $display("FAIL rstmid_held: got %h want 222222", eng_central);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, eng_en, rsp_valid, eng_central, eng_radius, eng_mode, rsp_id, rsp_candidate, rsp_err} !== '0) begin
            n_err++;
            $display("FAIL rstmid_clear: got en=%b rv=%b eng=%h/%h/%h id=%0d cand=%0d err=%b want 0",
                     eng_en, rsp_valid, eng_central, eng_radius, eng_mode, rsp_id, rsp_candidate, rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_job(1, 24'h010101, 12'h101, 2'd1);
        set_job(3, 24'h030303, 12'h303, 2'd3);
        exp_q.push_back('{3'd1, cand_model(24'h010101, 12'h101, 2'd1), 1'b0});
        req_valid = 4'b1010;
        #1;
        n_vec++;
        if (req_ready !== 4'b0010) begin
            n_err++;
            $display("FAIL rstmid_grant: got %b want 0010", req_ready);
        end
        @(negedge clk);
        #1;
        req_valid = '0;
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin @(negedge clk); #1; cyc++; end
        e = exp_q.pop_front();
        n_vec++;
        if (cyc != 67 || {rsp_id, rsp_candidate, rsp_err} !== {e.id, e.cand, e.err}) begin
            n_err++;
            $display("FAIL rstmid_rsp: got %0d cycles id=%0d cand=%0d err=%b want 67 id=%0d cand=%0d err=%b",
                     cyc, rsp_id, rsp_candidate, rsp_err, e.id, e.cand, e.err);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_central = '0;
        req_radius = '0;
        req_mode = '0;
        rsp_ready = 1'b1;
        test_reset;
        test_round_robin;
        test_single;
        test_timeout;
        test_resp_stall;
        test_simul_timeout;
        test_reset_mid_job;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
